// File: rtl/wb_spike_master_if.sv
// Wishbone classic bus between wb_spike_master and its slave.
interface wb_spike_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_spike_master.sv
// Wishbone master that forwards axon spikes, signals end-of-picture and
// reads back one spike-out word per slice, with a per-transfer bus timeout.
module wb_spike_master #(
  parameter logic [31:0] SPIKE_IN_ADDR   = 32'h3000_0800,
  parameter logic [31:0] DONE_PIC_ADDR   = 32'h3000_0840,
  parameter logic [31:0] SPIKE_OUT_BASE0 = 32'h3000_0600,
  parameter logic [31:0] CORE_PADDING    = 32'h0000_1000,
  parameter int          NUM_OF_SLICE    = 8,
  parameter int          TIMEOUT         = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spk_valid_i,
  input  logic [7:0]        spk_axon_i,
  output logic              spk_ready_o,
  input  logic              pic_valid_i,
  output logic              pic_ready_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [31:0]       res_data_o,
  output logic [2:0]        res_idx_o,
  output logic              busy_o,
  output logic              err_o,
  wb_spike_master_if.master wb
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    K_LAST  = 3'(NUM_OF_SLICE - 1);

  typedef enum logic [2:0] {IDLE, SPK_WR, DONE_WR, RD, RES_OUT} state_e;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d, resData_q, resData_d;
  logic [2:0]      k_q, k_d, resIdx_q, resIdx_d;
  logic [TW-1:0]   toCnt_q, toCnt_d;
  logic            err_q, err_d;
  logic            ackSeen, timedOut;

  // An ack only counts while stb is up; an ack in the last allowed cycle wins over the timeout.
  assign ackSeen  = stb_q & wb.wbm_ack_i;
  assign timedOut = stb_q & ~wb.wbm_ack_i & (toCnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (spk_valid_i)      state_d = SPK_WR;
        else if (pic_valid_i) state_d = DONE_WR;
      end
      SPK_WR:  if (ackSeen || timedOut) state_d = IDLE;
      DONE_WR: begin
        if (ackSeen)       state_d = RD;
        else if (timedOut) state_d = IDLE;
      end
      RD: begin
        if (ackSeen)       state_d = RES_OUT;
        else if (timedOut) state_d = IDLE;
      end
      RES_OUT: if (res_ready_i) state_d = (k_q == K_LAST) ? IDLE : RD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spk_ready_o = (state_q == IDLE);
    pic_ready_o = (state_q == IDLE) && !spk_valid_i;
    res_valid_o = (state_q == RES_OUT);
    busy_o      = (state_q != IDLE);
  end

  // RD is entered with stb low so every read is preceded by one idle bus cycle.
  always_comb begin
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    k_d       = k_q;
    toCnt_d   = toCnt_q;
    err_d     = err_q;
    resData_d = resData_q;
    resIdx_d  = resIdx_q;
    unique case (state_q)
      IDLE: begin
        if (spk_valid_i || pic_valid_i) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = 4'hF;
          toCnt_d = '0;
          adr_d   = spk_valid_i ? SPIKE_IN_ADDR : DONE_PIC_ADDR;
          dat_d   = spk_valid_i ? {24'h0, spk_axon_i} : 32'h1;
        end
      end
      SPK_WR, DONE_WR, RD: begin
        if (state_q == RD && !stb_q) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'hF;
          toCnt_d = '0;
          adr_d   = SPIKE_OUT_BASE0 + 32'(k_q) * CORE_PADDING;
        end else if (ackSeen) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = 4'h0;
          if (state_q == RD) begin
            resData_d = wb.wbm_dat_i;
            resIdx_d  = k_q;
          end
        end else if (timedOut) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = 4'h0;
          err_d = 1'b1;
          k_d   = '0;
        end else if (stb_q) begin
          toCnt_d = toCnt_q + 1'b1;
        end
      end
      RES_OUT: if (res_ready_i) k_d = (k_q == K_LAST) ? 3'd0 : k_q + 3'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= '0;
      dat_q     <= '0;
      k_q       <= '0;
      toCnt_q   <= '0;
      err_q     <= 1'b0;
      resData_q <= '0;
      resIdx_q  <= '0;
    end else begin
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      k_q       <= k_d;
      toCnt_q   <= toCnt_d;
      err_q     <= err_d;
      resData_q <= resData_d;
      resIdx_q  <= resIdx_d;
    end
  end

  assign wb.wbm_cyc_o = cyc_q;
  assign wb.wbm_stb_o = stb_q;
  assign wb.wbm_we_o  = we_q;
  assign wb.wbm_sel_o = sel_q;
  assign wb.wbm_adr_o = adr_q;
  assign wb.wbm_dat_o = dat_q;
  assign res_data_o   = resData_q;
  assign res_idx_o    = resIdx_q;
  assign err_o        = err_q;

endmodule
